meas_sequencer: RTL and testbench
=================================

// Module: meas_sequencer
// PURPOSE
//  Schedules repeated DAC-transmit / ADC-receive measurement bursts in the clk_100 domain.
//  Per burst it: pulses fifo_rst, drives enTx until Tx reports overTx, then drives enRe until Re reports overRe,
//  then waits a fixed gap. After N_BURSTS bursts it reports done.
//  Sits between the key/start logic and the Tx/Re datapaths. Adds burst repetition, timeouts and abort handling.
// PARAMETERS
//  N_BURSTS        8        bursts per measurement; >=1 (elaboration error if 0)
//  GAP_CYCLES      100000   idle clk_100 cycles between bursts (1 ms); >=1
//  FIFO_RST_CYCLES 16       fifo_rst pulse length in cycles; >=1
//  TIMEOUT_CYCLES  1000000  max cycles allowed in TX or RX before error; >=2
//  CNT_W           8        width of burst_cnt; 2**CNT_W > N_BURSTS
// PORTS
//  clk_100      in   1      100 MHz system clock; all logic on rising edge
//  rst_n        in   1      asynchronous active-low reset
//  start        in   1      single-cycle start request (debounced key)
//  abort        in   1      level; forces return to IDLE
//  overTx       in   1      Tx finished waveform (pulse or level)
//  overRe       in   1      Re finished capture (pulse or level)
//  enTx         out  1      Tx enable
//  enRe         out  1      Re/ADC capture enable
//  beginSignal  out  1      one-cycle marker at start of each capture
//  fifo_rst     out  1      capture FIFO reset
//  busy         out  1      high in every state except IDLE
//  done         out  1      one-cycle pulse on normal completion
//  err_timeout  out  1      sticky timeout flag
//  burst_cnt    out  CNT_W  completed bursts in current measurement
// BEHAVIOUR
//  - Reset: state=IDLE; all outputs 0; burst_cnt=0; err_timeout=0; internal counters 0.
//  - Outputs are flops updated with the state register. Each is high exactly in the cycles its state is current.
//  - States and transitions:
//    - IDLE: start=1 and abort=0 -> FRST; clear burst_cnt and err_timeout.
//    - FRST: fifo_rst=1 for FIFO_RST_CYCLES cycles -> TX.
//    - TX: enTx=1; overTx=1 -> RX (enTx low next cycle).
//    - RX: enRe=1. beginSignal=1 only in the first RX cycle.
//      overRe=1 -> GAP, with burst_cnt+1 in the same edge.
//    - GAP: all enables 0 for GAP_CYCLES cycles.
//      If burst_cnt==N_BURSTS -> DONE; else -> FRST.
//    - DONE: done=1 for one cycle -> IDLE. burst_cnt holds until next start.
//  - Latency: start at edge n -> fifo_rst high n+1..n+FIFO_RST_CYCLES -> enTx high from n+FIFO_RST_CYCLES+1.
//  - overTx is sampled only in TX; overRe is sampled only in RX. Elsewhere both are ignored.
//    overRe asserted during TX has no effect.
//  - Timeout: a cycle counter is cleared on entry to TX and on entry to RX.
//    If it reaches TIMEOUT_CYCLES-1 with no over* seen -> IDLE, err_timeout=1, no done pulse, burst_cnt frozen.
//  - over* and timeout in the same cycle: over* wins.
//  - abort=1 in any state -> IDLE next edge; all enables/fifo_rst 0; no done; err_timeout unchanged.
//  - abort beats start in the same cycle.
//  - start while busy is ignored (no restart, no queuing).
//  - rst_n low mid-burst: all outputs drop immediately (async); resume in IDLE.
// TESTING
//  Use N_BURSTS=3, GAP_CYCLES=5, FIFO_RST_CYCLES=4, TIMEOUT_CYCLES=50 in sim.
//  1 Nominal: start @t0; overTx 10 cycles after enTx rises; overRe 20 cycles after enRe rises.
//    -> 3 bursts; fifo_rst 4 cycles each; one beginSignal per burst; burst_cnt 1,2,3; done one pulse; busy falls with done.
//  2 Latency: start @edge 0 -> fifo_rst 1..4, enTx from 5; overTx @k -> enTx=0, enRe=1, beginSignal=1 @k+1.
//  3 Timeout: never assert overRe in burst 2 -> enRe high 50 cycles then 0; err_timeout=1; burst_cnt=1; no done.
//    A later start clears err_timeout.
//  4 Abort mid-TX of burst 2 -> next edge IDLE, enTx=0, busy=0, done never pulses; start then runs a full 3-burst sequence.
//  5 Ignored events: start pulses during GAP and RX, overRe during TX, start+abort together in IDLE
//    -> no state change beyond spec; sequence count unaffected.
//  6 Async reset in RX -> enRe/busy 0 without a clock edge; after release all outputs 0, burst_cnt 0.

Source files
------------

// File: rtl/meas_sequencer.sv
// Burst scheduler for DAC transmit / ADC receive measurements in the clk_100 domain.
// Each burst runs FIFO reset, TX, RX and an idle gap; done pulses after N_BURSTS bursts.
module meas_sequencer #(
  parameter int N_BURSTS        = 8,
  parameter int GAP_CYCLES      = 100000,
  parameter int FIFO_RST_CYCLES = 16,
  parameter int TIMEOUT_CYCLES  = 1000000,
  parameter int CNT_W           = 8
) (
  input  logic             clk_100,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic             overTx,
  input  logic             overRe,
  output logic             enTx,
  output logic             enRe,
  output logic             beginSignal,
  output logic             fifo_rst,
  output logic             busy,
  output logic             done,
  output logic             err_timeout,
  output logic [CNT_W-1:0] burst_cnt,
  output logic [2:0]       dbg_state
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_FRST = 3'd1;
  localparam logic [2:0] S_TX   = 3'd2;
  localparam logic [2:0] S_RX   = 3'd3;
  localparam logic [2:0] S_GAP  = 3'd4;
  localparam logic [2:0] S_DONE = 3'd5;

  localparam int MAX_A = (GAP_CYCLES > FIFO_RST_CYCLES) ? GAP_CYCLES : FIFO_RST_CYCLES;
  localparam int MAX_C = (MAX_A > TIMEOUT_CYCLES) ? MAX_A : TIMEOUT_CYCLES;
  localparam int CW    = $clog2(MAX_C + 1);

  generate
    if (N_BURSTS < 1) begin : g_bad_bursts
      $error("meas_sequencer: N_BURSTS must be >= 1");
    end
    if (GAP_CYCLES < 1 || FIFO_RST_CYCLES < 1 || TIMEOUT_CYCLES < 2) begin : g_bad_cycles
      $error("meas_sequencer: cycle parameters out of range");
    end
    if ((2 ** CNT_W) <= N_BURSTS) begin : g_bad_cnt_w
      $error("meas_sequencer: CNT_W too narrow for N_BURSTS");
    end
  endgenerate

  logic [2:0]       state, state_nxt;
  logic [CW-1:0]    cnt, cnt_nxt;
  logic [CNT_W-1:0] bc_nxt;
  logic             err_nxt;

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt + 1'b1;
    bc_nxt    = burst_cnt;
    err_nxt   = err_timeout;
    case (state)
      S_IDLE: begin
        cnt_nxt = '0;
        if (start) begin
          state_nxt = S_FRST;
          bc_nxt    = '0;
          err_nxt   = 1'b0;
        end
      end
      S_FRST: begin
        if (cnt == CW'(FIFO_RST_CYCLES - 1)) begin
          state_nxt = S_TX;
          cnt_nxt   = '0;
        end
      end
      // over* takes priority over a timeout landing in the same cycle
      S_TX: begin
        if (overTx) begin
          state_nxt = S_RX;
          cnt_nxt   = '0;
        end else if (cnt == CW'(TIMEOUT_CYCLES - 1)) begin
          state_nxt = S_IDLE;
          cnt_nxt   = '0;
          err_nxt   = 1'b1;
        end
      end
      S_RX: begin
        if (overRe) begin
          state_nxt = S_GAP;
          cnt_nxt   = '0;
          bc_nxt    = burst_cnt + 1'b1;
        end else if (cnt == CW'(TIMEOUT_CYCLES - 1)) begin
          state_nxt = S_IDLE;
          cnt_nxt   = '0;
          err_nxt   = 1'b1;
        end
      end
      S_GAP: begin
        if (cnt == CW'(GAP_CYCLES - 1)) begin
          cnt_nxt   = '0;
          state_nxt = (burst_cnt == CNT_W'(N_BURSTS)) ? S_DONE : S_FRST;
        end
      end
      S_DONE: begin
        state_nxt = S_IDLE;
        cnt_nxt   = '0;
      end
      default: begin
        state_nxt = S_IDLE;
        cnt_nxt   = '0;
      end
    endcase
    // abort overrides everything, including a same-cycle start, and leaves the flags alone
    if (abort) begin
      state_nxt = S_IDLE;
      cnt_nxt   = '0;
      bc_nxt    = burst_cnt;
      err_nxt   = err_timeout;
    end
  end

  // Outputs are decoded from the next state so they are registered alongside it.
  always_ff @(posedge clk_100 or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      cnt         <= '0;
      burst_cnt   <= '0;
      err_timeout <= 1'b0;
      enTx        <= 1'b0;
      enRe        <= 1'b0;
      beginSignal <= 1'b0;
      fifo_rst    <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      state       <= state_nxt;
      cnt         <= cnt_nxt;
      burst_cnt   <= bc_nxt;
      err_timeout <= err_nxt;
      enTx        <= (state_nxt == S_TX);
      enRe        <= (state_nxt == S_RX);
      beginSignal <= (state_nxt == S_RX) && (state != S_RX);
      fifo_rst    <= (state_nxt == S_FRST);
      busy        <= (state_nxt != S_IDLE);
      done        <= (state_nxt == S_DONE);
    end
  end

  assign dbg_state = state;

endmodule

// File: tb/tb_meas_sequencer.sv
// Directed bench for meas_sequencer: a per-cycle vector table for one burst plus
// hand-written sequences for nominal runs, timeout, abort and asynchronous reset.
module tb_meas_sequencer;

  localparam int N_B  = 3;
  localparam int GAP  = 5;
  localparam int FRST = 4;
  localparam int TO   = 50;

  logic       clk_100 = 1'b0;
  logic       rst_n;
  logic       start, abort, over_tx, over_re;
  logic       en_tx, en_re, begin_sig, fifo_rst, busy, done, err_timeout;
  logic [7:0] burst_cnt;
  logic [2:0] dbg_state;

  int total = 0;
  int bad   = 0;
  int n_frst, n_begin, n_done;

  meas_sequencer #(
    .N_BURSTS(N_B), .GAP_CYCLES(GAP), .FIFO_RST_CYCLES(FRST),
    .TIMEOUT_CYCLES(TO), .CNT_W(8)
  ) dut (
    .clk_100(clk_100), .rst_n(rst_n), .start(start), .abort(abort),
    .overTx(over_tx), .overRe(over_re), .enTx(en_tx), .enRe(en_re),
    .beginSignal(begin_sig), .fifo_rst(fifo_rst), .busy(busy), .done(done),
    .err_timeout(err_timeout), .burst_cnt(burst_cnt), .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk_100 = ~clk_100;

  always @(negedge clk_100) begin
    if (fifo_rst)  n_frst++;
    if (begin_sig) n_begin++;
    if (done)      n_done++;
  end

  typedef struct {
    logic       start, abort, otx, ore;
    logic [6:0] exp;  // {fifo_rst, en_tx, en_re, begin, busy, done, err_timeout}
    logic [7:0] cnt;
  } vec_t;
  vec_t vq[$];

  // scoreboard helpers
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk_100);
    #1;
  endtask

  task automatic clr_mon();
    n_frst = 0; n_begin = 0; n_done = 0;
  endtask

  function automatic logic sel(input int w);
    case (w)
      0: return en_tx;
      1: return en_re;
      default: return done;
    endcase
  endfunction

  task automatic wait_high(input int w, input string name);
    int n = 0;
    while (!sel(w) && n < 200) begin
      step();
      n++;
    end
    chk(name, {31'd0, sel(w)}, 1);
  endtask

  // driver tasks
  task automatic pulse_start();
    start = 1'b1; step(); start = 1'b0;
  endtask

  task automatic run_burst(input int b, input int tx_dly, input int re_dly);
    wait_high(0, "wait_en_tx");
    repeat (tx_dly - 1) step();
    over_tx = 1'b1; step(); over_tx = 1'b0;
    chk("tx_drop", {31'd0, en_tx}, 0);
    chk("rx_rise", {31'd0, en_re}, 1);
    chk("begin_first", {31'd0, begin_sig}, 1);
    chk("cnt_in_rx", burst_cnt, b);
    repeat (re_dly - 1) step();
    over_re = 1'b1; step(); over_re = 1'b0;
    chk("rx_drop", {31'd0, en_re}, 0);
    chk("cnt_inc", burst_cnt, b + 1);
  endtask

  task automatic run_full(input int tx_dly, input int re_dly);
    clr_mon();
    pulse_start();
    for (int b = 0; b < N_B; b++) run_burst(b, tx_dly, re_dly);
    wait_high(2, "wait_done");
    chk("busy_at_done", {31'd0, busy}, 1);
    step();
    chk("done_one_cycle", {31'd0, done}, 0);
    chk("busy_after_done", {31'd0, busy}, 0);
    chk("cnt_hold", burst_cnt, N_B);
    chk("frst_cycles", n_frst, N_B * FRST);
    chk("begin_pulses", n_begin, N_B);
    chk("done_pulses", n_done, 1);
  endtask

  initial begin
    int n;
    rst_n = 1'b0; start = 0; abort = 0; over_tx = 0; over_re = 0;
    clr_mon();
    repeat (2) @(posedge clk_100);
    #1;
    chk("rst_outputs", {busy, done, en_tx, en_re, fifo_rst, begin_sig, err_timeout}, 0);
    chk("rst_cnt", burst_cnt, 0);
    chk("rst_state", dbg_state, 0);
    @(negedge clk_100);
    rst_n = 1'b1;
    step();

    // one burst cycle by cycle: latency, ignored start/overRe/overTx, abort and abort+start
    vq.push_back('{0, 0, 0, 0, 7'b0000000, 8'd0});
    vq.push_back('{1, 0, 0, 0, 7'b1000100, 8'd0});
    vq.push_back('{0, 0, 0, 0, 7'b1000100, 8'd0});
    vq.push_back('{1, 0, 0, 0, 7'b1000100, 8'd0});
    vq.push_back('{0, 0, 0, 0, 7'b1000100, 8'd0});
    vq.push_back('{0, 0, 0, 1, 7'b0100100, 8'd0});
    vq.push_back('{0, 0, 0, 1, 7'b0100100, 8'd0});
    vq.push_back('{0, 0, 1, 0, 7'b0011100, 8'd0});
    vq.push_back('{0, 0, 0, 0, 7'b0010100, 8'd0});
    vq.push_back('{1, 0, 0, 0, 7'b0010100, 8'd0});
    vq.push_back('{0, 0, 0, 1, 7'b0000100, 8'd1});
    vq.push_back('{0, 0, 0, 0, 7'b0000100, 8'd1});
    vq.push_back('{1, 0, 0, 0, 7'b0000100, 8'd1});
    vq.push_back('{0, 0, 1, 0, 7'b0000100, 8'd1});
    vq.push_back('{0, 0, 0, 0, 7'b0000100, 8'd1});
    vq.push_back('{0, 0, 0, 0, 7'b1000100, 8'd1});
    vq.push_back('{0, 1, 0, 0, 7'b0000000, 8'd1});
    vq.push_back('{1, 1, 0, 0, 7'b0000000, 8'd1});
    vq.push_back('{0, 0, 0, 0, 7'b0000000, 8'd1});
    for (int i = 0; i < vq.size(); i++) begin
      start = vq[i].start; abort = vq[i].abort; over_tx = vq[i].otx; over_re = vq[i].ore;
      step();
      chk($sformatf("vec%0d_out", i),
          {fifo_rst, en_tx, en_re, begin_sig, busy, done, err_timeout}, vq[i].exp);
      chk($sformatf("vec%0d_cnt", i), burst_cnt, vq[i].cnt);
    end
    start = 0; abort = 0; over_tx = 0; over_re = 0;
    step();

    // nominal three-burst measurement
    run_full(10, 20);

    // timeout: burst 2 never sees overRe
    clr_mon();
    pulse_start();
    run_burst(0, 3, 4);
    wait_high(0, "to_wait_en_tx");
    over_tx = 1'b1; step(); over_tx = 1'b0;
    n = 0;
    while (en_re && n < 100) begin
      n++;
      step();
    end
    chk("to_rx_cycles", n, TO);
    chk("to_err", {31'd0, err_timeout}, 1);
    chk("to_cnt", burst_cnt, 1);
    chk("to_busy", {31'd0, busy}, 0);
    repeat (3) step();
    chk("to_no_done", n_done, 0);
    chk("to_err_sticky", {31'd0, err_timeout}, 1);
    pulse_start();
    chk("to_err_clr", {31'd0, err_timeout}, 0);
    chk("to_cnt_clr", burst_cnt, 0);
    abort = 1'b1; step(); abort = 1'b0;
    step();

    // abort in TX of burst 2, then a complete run
    clr_mon();
    pulse_start();
    run_burst(0, 2, 2);
    wait_high(0, "ab_wait_en_tx");
    step();
    abort = 1'b1; step(); abort = 1'b0;
    chk("ab_en_tx", {31'd0, en_tx}, 0);
    chk("ab_busy", {31'd0, busy}, 0);
    chk("ab_state", dbg_state, 0);
    repeat (10) step();
    chk("ab_no_done", n_done, 0);
    chk("ab_idle_hold", {31'd0, busy}, 0);
    run_full(2, 3);

    // asynchronous reset while in RX
    pulse_start();
    wait_high(0, "rs_wait_en_tx");
    over_tx = 1'b1; step(); over_tx = 1'b0;
    chk("rs_in_rx", {31'd0, en_re}, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("rs_en_re_async", {31'd0, en_re}, 0);
    chk("rs_busy_async", {31'd0, busy}, 0);
    @(negedge clk_100);
    rst_n = 1'b1;
    step();
    chk("rs_outputs", {busy, done, en_tx, en_re, fifo_rst, begin_sig, err_timeout}, 0);
    chk("rs_cnt", burst_cnt, 0);

    // final report
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
